// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: power wait, precharge-all, N auto-refreshes, mode load.
// Optional extended-mode load enabled by defining SDRAM_INIT_EMRS_EN.
`timescale 1ns/1ps
module sdram_init_seq #(
    parameter int          ADDR_W       = 12,
    parameter int          BA_W         = 2,
    parameter int          T_POWER_CYC  = 15000,
    parameter int          T_RP_CYC     = 2,
    parameter int          T_RFC_CYC    = 7,
    parameter int          T_MRD_CYC    = 2,
    parameter int          INIT_REF_NUM = 8,
    parameter logic [31:0] MODE_WORD    = 32'h037,
    parameter logic [31:0] EMODE_WORD   = 32'h000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              reinit_req,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_ba,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_done,
    output logic              init_busy,
    output logic [7:0]        ref_count
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam logic [3:0] ST_POWER_WAIT = 4'd0;
    localparam logic [3:0] ST_PRE        = 4'd1;
    localparam logic [3:0] ST_WAIT_RP    = 4'd2;
    localparam logic [3:0] ST_REF        = 4'd3;
    localparam logic [3:0] ST_WAIT_RFC   = 4'd4;
    localparam logic [3:0] ST_LMR        = 4'd5;
    localparam logic [3:0] ST_WAIT_MRD   = 4'd6;
`ifdef SDRAM_INIT_EMRS_EN
    localparam logic [3:0] ST_EMRS       = 4'd7;
    localparam logic [3:0] ST_WAIT_EMRD  = 4'd8;
`endif
    localparam logic [3:0] ST_DONE       = 4'd9;

    localparam int T_MAX_A = (T_RP_CYC > T_RFC_CYC) ? T_RP_CYC : T_RFC_CYC;
    localparam int T_MAX   = (T_MAX_A > T_MRD_CYC) ? T_MAX_A : T_MRD_CYC;
    localparam int WAIT_W  = $clog2(T_MAX + 1);
    localparam int PWR_W   = $clog2(T_POWER_CYC + 1);

    // The wait counter is loaded with 1 in the command cycle, so a wait state lasts T-1 cycles.
    localparam logic [WAIT_W-1:0] RP_LAST  = WAIT_W'(T_RP_CYC - 1);
    localparam logic [WAIT_W-1:0] RFC_LAST = WAIT_W'(T_RFC_CYC - 1);
    localparam logic [WAIT_W-1:0] MRD_LAST = WAIT_W'(T_MRD_CYC - 1);
    localparam logic [PWR_W-1:0]  PWR_LAST = PWR_W'(T_POWER_CYC - 1);
    localparam logic [7:0]        REF_TARGET = 8'(INIT_REF_NUM);

    logic [3:0]        state_q, state_d;
    logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d, pwr_inc;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic [7:0]        ref_cnt_q, ref_cnt_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    assign pwr_inc  = (&pwr_cnt_q)  ? pwr_cnt_q  : pwr_cnt_q + PWR_W'(1);
    assign wait_inc = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

    always_comb begin
        state_d    = state_q;
        pwr_cnt_d  = pwr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ref_cnt_d  = ref_cnt_q;
        case (state_q)
            ST_POWER_WAIT: begin
                pwr_cnt_d = pwr_inc;
                if (pwr_cnt_q == PWR_LAST) state_d = ST_PRE;
            end
            ST_PRE: begin
                state_d    = ST_WAIT_RP;
                wait_cnt_d = WAIT_W'(1);
            end
            ST_WAIT_RP: begin
                wait_cnt_d = wait_inc;
                if (wait_cnt_q >= RP_LAST) state_d = ST_REF;
            end
            ST_REF: begin
                state_d    = ST_WAIT_RFC;
                wait_cnt_d = WAIT_W'(1);
                if (ref_cnt_q != 8'hFF) ref_cnt_d = ref_cnt_q + 8'd1;
            end
            ST_WAIT_RFC: begin
                wait_cnt_d = wait_inc;
                if (wait_cnt_q >= RFC_LAST)
                    state_d = (ref_cnt_q < REF_TARGET) ? ST_REF : ST_LMR;
            end
            ST_LMR: begin
                state_d    = ST_WAIT_MRD;
                wait_cnt_d = WAIT_W'(1);
            end
            ST_WAIT_MRD: begin
                wait_cnt_d = wait_inc;
`ifdef SDRAM_INIT_EMRS_EN
                if (wait_cnt_q >= MRD_LAST) state_d = ST_EMRS;
            end
            ST_EMRS: begin
                state_d    = ST_WAIT_EMRD;
                wait_cnt_d = WAIT_W'(1);
            end
            ST_WAIT_EMRD: begin
                wait_cnt_d = wait_inc;
                if (wait_cnt_q >= MRD_LAST) state_d = ST_DONE;
`else
                if (wait_cnt_q >= MRD_LAST) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (reinit_req) state_d = ST_PRE;
            end
            default: state_d = ST_POWER_WAIT;
        endcase
        if (state_d == ST_PRE) ref_cnt_d = 8'd0;
    end

    // Bus outputs are a registered decode of the current state, so they lag the state by one cycle.
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = '1;
        addr_d = '1;
        done_d = 1'b0;
        case (state_q)
            ST_PRE: cmd_d = CMD_PRE;
            ST_REF: cmd_d = CMD_REF;
            ST_LMR: begin
                cmd_d  = CMD_LMR;
                ba_d   = '0;
                addr_d = MODE_WORD[ADDR_W-1:0];
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                cmd_d            = CMD_LMR;
                ba_d             = '0;
                ba_d[BA_W-1]     = 1'b1;
                addr_d           = EMODE_WORD[ADDR_W-1:0];
            end
`endif
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_POWER_WAIT;
            pwr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ref_cnt_q  <= 8'd0;
            cmd_q      <= CMD_NOP;
            ba_q       <= '1;
            addr_q     <= '1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwr_cnt_q  <= pwr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
        end
    end

    assign init_cmd  = cmd_q;
    assign init_ba   = ba_q;
    assign init_addr = addr_q;
    assign init_done = done_q;
    assign init_busy = ~done_q;
    assign ref_count = ref_cnt_q;

endmodule
